// File: rtl/ws2812b_frame_sched.sv
// Frame scheduler for the WS2812B pixel driver: one start per frame period, reset-gap enforcement,
// double-buffer bank swapping. Define WS2812B_SCHED_TIMEOUT_EN to add the busy/done watchdog and err.
module ws2812b_frame_sched #(
  parameter int FRAME_CLKS   = 400000,
  parameter int GAP_CLKS     = 1200,
  parameter int TIMEOUT_CLKS = 16000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [8:0] leds_cfg,
  input  logic       wr_done,
  input  logic       tx_busy,
  output logic       start,
  output logic       bank,
  output logic [8:0] leds,
  output logic       wr_bank,
  output logic       swap_ack,
  output logic       active,
`ifdef WS2812B_SCHED_TIMEOUT_EN
  output logic       err,
`endif
  output logic [7:0] overrun_cnt
);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t      state;
  logic [23:0] frame_cnt;
  logic [31:0] gap_cnt;
  logic        disp_bank;
  logic        swap_pend;
  logic        frame_tick;
  logic        launch;
  logic        pend_now;
`ifdef WS2812B_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;
`endif

  assign frame_tick = (frame_cnt == 24'(FRAME_CLKS - 1));
  assign launch     = frame_tick && enable && (leds_cfg != 9'd0) && (state == IDLE);
  // Outputs are registered, so the swap decision is taken on the launch edge using the value
  // swap_pend will hold during START; a wr_done during START re-arms it for the next frame.
  assign pend_now   = swap_pend | wr_done;
  assign wr_bank    = ~disp_bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      gap_cnt     <= '0;
      disp_bank   <= 1'b0;
      swap_pend   <= 1'b0;
      start       <= 1'b0;
      bank        <= 1'b0;
      leds        <= '0;
      swap_ack    <= 1'b0;
      active      <= 1'b0;
      overrun_cnt <= '0;
`ifdef WS2812B_SCHED_TIMEOUT_EN
      wd_cnt      <= '0;
      err         <= 1'b0;
`endif
    end else begin
      start     <= 1'b0;
      swap_ack  <= 1'b0;
      swap_pend <= pend_now;
      frame_cnt <= frame_tick ? '0 : frame_cnt + 24'd1;

      if (frame_tick && (state != IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (launch) begin
            state  <= START;
            start  <= 1'b1;
            active <= 1'b1;
            leds   <= (leds_cfg > 9'd256) ? 9'd256 : leds_cfg;
            if (pend_now) begin
              disp_bank <= ~disp_bank;
              bank      <= ~disp_bank;
              swap_ack  <= 1'b1;
              swap_pend <= 1'b0;
            end else begin
              bank <= disp_bank;
            end
          end
        end
        START: begin
          state <= WAIT_BUSY;
`ifdef WS2812B_SCHED_TIMEOUT_EN
          // Counts waiting cycles inclusively, so err rises TIMEOUT_CLKS cycles after start.
          wd_cnt <= 32'd1;
`endif
        end
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == 32'(GAP_CLKS - 1)) begin
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase

`ifdef WS2812B_SCHED_TIMEOUT_EN
      if (state == WAIT_BUSY || state == WAIT_DONE) begin
        if (wd_cnt >= 32'(TIMEOUT_CLKS - 1)) begin
          err     <= 1'b1;
          state   <= GAP;
          gap_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
        end
      end
`endif
    end
  end

endmodule
